// File: rtl/alu_wb_skid_stage_pkg.sv
// Shared definitions for the ALU write-back skid stage: field encodings, widths,
// the buffered entry layout and the occupancy state.
package alu_wb_skid_stage_pkg;

    localparam int DW    = 128;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    typedef enum logic [2:0] {
        PPP_A = 3'b000,
        PPP_U = 3'b001,
        PPP_D = 3'b010,
        PPP_E = 3'b011,
        PPP_O = 3'b100
    } ppp_e;

    typedef enum logic [1:0] {
        W8  = 2'b00,
        W16 = 2'b01,
        W32 = 2'b10,
        W64 = 2'b11
    } ww_e;

    // Occupancy doubles as the FSM state: the encoding is the entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic [0:DW-1] data;
        logic [0:AW-1] rd;
        logic          wen;
    } wb_entry_t;

endpackage

// File: rtl/alu_wb_skid_stage_if.sv
// Upstream (ALU) and downstream (register file) handshake bundle of the write-back stage.
interface alu_wb_skid_stage_if;
    import alu_wb_skid_stage_pkg::*;

    logic          in_valid;
    logic          in_ready;
    logic [0:DW-1] in_result;
    logic [0:DW-1] in_old;
    logic [0:AW-1] in_rd;
    logic          in_wen;
    logic [0:2]    in_ppp;
    logic [0:1]    in_ww;

    logic          out_valid;
    logic          out_ready;
    logic [0:DW-1] out_data;
    logic [0:AW-1] out_rd;
    logic          out_wen;

    modport master (
        output in_valid, in_result, in_old, in_rd, in_wen, in_ppp, in_ww,
        input  in_ready,
        input  out_valid, out_data, out_rd, out_wen,
        output out_ready
    );

    modport slave (
        input  in_valid, in_result, in_old, in_rd, in_wen, in_ppp, in_ww,
        output in_ready,
        output out_valid, out_data, out_rd, out_wen,
        input  out_ready
    );

endinterface

// File: rtl/alu_wb_skid_stage_mask.sv
// Participation mask generator: bit k of mask selects in_result over the old register value.
// Bit 0 is the MSB and element 0 the most significant element.
module wb_ppp_mask
    import alu_wb_skid_stage_pkg::*;
(
    input  logic [0:2]    in_ppp,
    input  logic [0:1]    in_ww,
    output logic [0:DW-1] mask,
    output logic          ppp_ok
);

    assign ppp_ok = (in_ppp <= PPP_O);

    for (genvar k = 0; k < DW; k++) begin : g_bit
        localparam logic [6:0] KIDX = 7'(k);
        logic elem_odd;
        logic bit_sel;

        // Element parity is simply bit (3+ww) of the bit index.
        assign elem_odd = (in_ww == W8)  ? KIDX[3] :
                          (in_ww == W16) ? KIDX[4] :
                          (in_ww == W32) ? KIDX[5] : KIDX[6];

        always_comb begin
            bit_sel = 1'b0;
            case (in_ppp)
                PPP_A:   bit_sel = 1'b1;
                PPP_U:   bit_sel = ~KIDX[6];
                PPP_D:   bit_sel = KIDX[6];
                PPP_E:   bit_sel = ~elem_odd;
                PPP_O:   bit_sel = elem_odd;
                default: bit_sel = 1'b0;
            endcase
        end

        assign mask[k] = bit_sel;
    end

endmodule

// File: rtl/alu_wb_skid_stage.sv
// Write-back stage: merges the ALU result into the old register value and buffers the
// write in a 2-entry skid FIFO in front of the register-file write port.
module alu_wb_skid_stage
    import alu_wb_skid_stage_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    alu_wb_skid_stage_if.slave bus
);

    logic [0:DW-1] mask;
    logic          ppp_ok;
    wb_entry_t     new_entry;
    wb_entry_t     entries [DEPTH];
    state_e        state;
    state_e        state_next;
    logic          head;
    logic          head_next;
    logic          tail;
    logic          push;
    logic          pop;

    wb_ppp_mask u_mask (
        .in_ppp (bus.in_ppp),
        .in_ww  (bus.in_ww),
        .mask   (mask),
        .ppp_ok (ppp_ok)
    );

    always_comb begin
        new_entry.data = (bus.in_result & mask) | (bus.in_old & ~mask);
        new_entry.rd   = bus.in_rd;
        new_entry.wen  = bus.in_wen & ppp_ok;
    end

    assign push = bus.in_valid  && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;
    assign tail = (state == ST_ONE) ? ~head : head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_EMPTY;
            head  <= 1'b0;
        end else begin
            state <= state_next;
            head  <= head_next;
        end
    end

    // Head only moves when another entry stays behind, so an empty FIFO keeps
    // presenting the last written entry.
    always_comb begin
        state_next = state;
        head_next  = head;
        case (state)
            ST_EMPTY: begin
                if (push) state_next = ST_ONE;
            end
            ST_ONE: begin
                if (push && !pop)      state_next = ST_TWO;
                else if (pop && !push) state_next = ST_EMPTY;
                else if (push && pop)  head_next  = ~head;
            end
            ST_TWO: begin
                if (pop) begin
                    state_next = ST_ONE;
                    head_next  = ~head;
                end
            end
            default: begin
                state_next = ST_EMPTY;
                head_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
        end else if (push) begin
            entries[tail] <= new_entry;
        end
    end

    always_comb begin
        bus.in_ready  = (state != ST_TWO);
        bus.out_valid = (state != ST_EMPTY);
        bus.out_data  = entries[head].data;
        bus.out_rd    = entries[head].rd;
        bus.out_wen   = entries[head].wen;
    end

endmodule

// File: tb/tb_alu_wb_skid_stage.sv
// Scoreboard bench for the write-back skid stage: accepted inputs are modelled and queued,
// register-file pops are collected and compared in FIFO order.
module tb_alu_wb_skid_stage;
    import alu_wb_skid_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alu_wb_skid_stage_if bus ();

    alu_wb_skid_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    wb_entry_t exp_q[$];
    wb_entry_t got_q[$];
    int checks = 0;
    int passed = 0;

    function automatic wb_entry_t model(input logic [0:127] res, input logic [0:127] old,
                                        input logic [2:0] ppp, input logic [1:0] ww,
                                        input logic [4:0] rd, input logic wen);
        logic [0:127] m;
        int esz;
        int idx;
        wb_entry_t e;
        esz = 8 << ww;
        for (int k = 0; k < 128; k++) begin
            idx = k / esz;
            case (ppp)
                3'd0:    m[k] = 1'b1;
                3'd1:    m[k] = (k < 64);
                3'd2:    m[k] = (k >= 64);
                3'd3:    m[k] = (idx % 2 == 0);
                3'd4:    m[k] = (idx % 2 == 1);
                default: m[k] = 1'b0;
            endcase
        end
        e.data = (res & m) | (old & ~m);
        e.rd   = rd;
        e.wen  = wen && (ppp <= 3'd4);
        return e;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (!reset && bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.in_result, bus.in_old, bus.in_ppp, bus.in_ww, bus.in_rd, bus.in_wen));
        if (!reset && bus.out_valid && bus.out_ready)
            got_q.push_back(wb_entry_t'({bus.out_data, bus.out_rd, bus.out_wen}));
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [0:127] res, input logic [0:127] old, input logic [2:0] ppp,
                         input logic [1:0] ww, input logic [4:0] rd, input logic wen);
        bus.in_valid  = 1'b1;
        bus.in_result = res;
        bus.in_old    = old;
        bus.in_ppp    = ppp;
        bus.in_ww     = ww;
        bus.in_rd     = rd;
        bus.in_wen    = wen;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && got_q.size() < exp_q.size(); c++) tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_result = '0; bus.in_old = '0; bus.in_rd = '0;
        bus.in_wen = 1'b0; bus.in_ppp = '0; bus.in_ww = '0; bus.out_ready = 1'b0;
        #12;
        checks++; if (bus.out_valid === 1'b0) passed++; else $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid);
        checks++; if (bus.in_ready === 1'b1) passed++; else $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        checks++; if (bus.out_data === '0) passed++; else $display("[TB] FAIL reset_out_data: got %h expected 0", bus.out_data);
        checks++; if ({bus.out_rd, bus.out_wen} === 6'd0) passed++; else $display("[TB] FAIL reset_rd_wen: got %h expected 0", {bus.out_rd, bus.out_wen});
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_all_latency();
        wb_entry_t e, g;
        bus.out_ready = 1'b1;
        drive({16{8'hAB}}, '0, 3'b000, 2'b00, 5'd7, 1'b1);
        tick();
        checks++; if (bus.out_valid === 1'b1) passed++; else $display("[TB] FAIL all_latency_valid: got %b expected 1", bus.out_valid);
        checks++; if (bus.out_data === {16{8'hAB}} && bus.out_rd === 5'd7 && bus.out_wen === 1'b1) passed++;
        else $display("[TB] FAIL all_latency_data: got %h/%0d/%b expected %h/7/1", bus.out_data, bus.out_rd, bus.out_wen, {16{8'hAB}});
        bus.in_valid = 1'b0;
        tick();
        checks++; if (bus.out_valid === 1'b0 && bus.out_data === {16{8'hAB}}) passed++;
        else $display("[TB] FAIL empty_hold: got valid=%b data=%h expected valid=0 data=%h", bus.out_valid, bus.out_data, {16{8'hAB}});
        drain();
        checks++; if (got_q.size() == exp_q.size()) passed++; else $display("[TB] FAIL all_count: got %0d entries expected %0d", got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g === e) passed++; else $display("[TB] FAIL all_entry: got %h expected %h", g, e);
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_even_odd_update();
        wb_entry_t e, g;
        bus.out_ready = 1'b1;
        drive({16{8'hFF}}, '0, 3'b011, 2'b00, 5'd3, 1'b1);
        tick();
        checks++; if (bus.out_data === {8{16'hFF00}}) passed++; else $display("[TB] FAIL even_w8: got %h expected %h", bus.out_data, {8{16'hFF00}});
        drive({16{8'hFF}}, '0, 3'b100, 2'b01, 5'd4, 1'b1);
        tick();
        checks++; if (bus.out_data === {4{32'h0000FFFF}}) passed++; else $display("[TB] FAIL odd_w16: got %h expected %h", bus.out_data, {4{32'h0000FFFF}});
        drive({16{8'h22}}, {16{8'h11}}, 3'b001, 2'b10, 5'd5, 1'b1);
        tick();
        checks++; if (bus.out_data === {{8{8'h22}}, {8{8'h11}}}) passed++; else $display("[TB] FAIL upper_w32: got %h expected %h", bus.out_data, {{8{8'h22}}, {8{8'h11}}});
        drive({16{8'h22}}, {16{8'h11}}, 3'b110, 2'b10, 5'd6, 1'b1);
        tick();
        checks++; if (bus.out_data === {16{8'h11}} && bus.out_wen === 1'b0) passed++;
        else $display("[TB] FAIL bad_ppp: got %h wen=%b expected %h wen=0", bus.out_data, bus.out_wen, {16{8'h11}});
        drain();
        checks++; if (got_q.size() == exp_q.size()) passed++; else $display("[TB] FAIL mask_count: got %0d entries expected %0d", got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g === e) passed++; else $display("[TB] FAIL mask_entry: got %h expected %h", g, e);
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_back_to_back();
        wb_entry_t e, g;
        int n;
        logic [4:0] want_rd;
        bus.out_ready = 1'b0;
        drive({8{16'h1234}}, {8{16'h5678}}, 3'b000, 2'b00, 5'd1, 1'b1);
        tick();
        bus.in_rd = 5'd2;
        tick();
        bus.in_rd = 5'd3;
        checks++; if (bus.in_ready === 1'b0) passed++; else $display("[TB] FAIL full_in_ready: got %b expected 0", bus.in_ready);
        tick(); tick();
        checks++; if (exp_q.size() == 2 && bus.out_rd === 5'd1) passed++;
        else $display("[TB] FAIL full_hold: got accepted=%0d head_rd=%0d expected 2 and 1", exp_q.size(), bus.out_rd);
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() < 3 && n < 10) begin tick(); n++; end
        checks++; if (exp_q.size() == 3) passed++; else $display("[TB] FAIL third_accept: got %0d accepted expected 3", exp_q.size());
        drain();
        checks++; if (got_q.size() == 3) passed++; else $display("[TB] FAIL b2b_count: got %0d entries expected 3", got_q.size());
        want_rd = 5'd1;
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g === e && g.rd === want_rd) passed++; else $display("[TB] FAIL b2b_entry: got %h expected %h rd %0d", g, e, want_rd);
            want_rd++;
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_push_pop();
        wb_entry_t e, g;
        bus.out_ready = 1'b0;
        drive({16{8'hA5}}, '0, 3'b010, 2'b11, 5'd10, 1'b1);
        tick();
        drive({16{8'h5A}}, {16{8'hC3}}, 3'b011, 2'b11, 5'd11, 1'b1);
        bus.out_ready = 1'b1;
        tick();
        checks++; if (bus.out_valid === 1'b1 && bus.in_ready === 1'b1 && bus.out_rd === 5'd11) passed++;
        else $display("[TB] FAIL push_pop_head: got valid=%b ready=%b rd=%0d expected 1/1/11", bus.out_valid, bus.in_ready, bus.out_rd);
        drain();
        checks++; if (got_q.size() == 2 && exp_q.size() == 2) passed++; else $display("[TB] FAIL push_pop_count: got %0d entries expected 2", got_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g === e) passed++; else $display("[TB] FAIL push_pop_entry: got %h expected %h", g, e);
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive({16{8'h77}}, '0, 3'b000, 2'b00, 5'd20, 1'b1);
        tick();
        bus.in_rd = 5'd21;
        tick();
        bus.in_valid = 1'b0;
        checks++; if (bus.in_ready === 1'b0 && bus.out_valid === 1'b1) passed++;
        else $display("[TB] FAIL pre_reset_full: got ready=%b valid=%b expected 0/1", bus.in_ready, bus.out_valid);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (bus.out_valid === 1'b0 && bus.in_ready === 1'b1 && bus.out_data === '0) passed++;
        else $display("[TB] FAIL async_reset: got valid=%b ready=%b data=%h expected 0/1/0", bus.out_valid, bus.in_ready, bus.out_data);
        exp_q.delete(); got_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        checks++; if (got_q.size() == 0 && bus.out_valid === 1'b0) passed++;
        else $display("[TB] FAIL stale_after_reset: got %0d entries valid=%b expected 0/0", got_q.size(), bus.out_valid);
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_random();
        wb_entry_t e, g;
        for (int c = 0; c < 80; c++) begin
            drive({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                  3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 5'($urandom), 1'($urandom));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        drain();
        checks++; if (got_q.size() == exp_q.size()) passed++; else $display("[TB] FAIL rand_count: got %0d entries expected %0d", got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
            if (g === e) passed++; else $display("[TB] FAIL rand_entry: got %h expected %h", g, e);
        end
        exp_q.delete(); got_q.delete();
    endtask

    initial begin
        test_reset();
        test_all_latency();
        test_even_odd_update();
        test_back_to_back();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
